// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with load-use hazard detection, stall sequencing,
// branch flush and a saturating stall-cycle counter.
module if_id_hazard_stage #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [31:0]      PC_Plus_4_IF,
    input  logic [31:0]      Instruction_IF,
    input  logic             MemRead_EX,
    input  logic [31:0]      Instruction_EX,
    input  logic             Branch_Taken_MEM,
    output logic [31:0]      PC_Plus_4_ID,
    output logic [31:0]      Instruction_ID,
    output logic             Valid_ID,
    output logic             PC_Write,
    output logic             Bubble_ID,
    output logic [CNT_W-1:0] Stall_Count
);

    typedef enum logic {RUN, STALL} state_t;

    localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);

    state_t     state;
    logic [2:0] stall_left;
    logic [4:0] rt_ex;
    logic [4:0] rs_id;
    logic [4:0] rt_id;
    logic       hazard;
    logic       stall_cycle;
    logic       unused_ex_bits;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign rt_ex          = Instruction_EX[20:16];
    assign rs_id          = Instruction_ID[25:21];
    assign rt_id          = Instruction_ID[20:16];
    assign unused_ex_bits = ^{Instruction_EX[31:21], Instruction_EX[15:0]};

    assign hazard      = Valid_ID & MemRead_EX & (rt_ex != 5'd0) &
                         ((rt_ex == rs_id) | (rt_ex == rt_id));
    assign stall_cycle = ((state == RUN) & hazard) | (state == STALL);
    // A taken branch restarts fetch, so the PC must move even mid-stall.
    assign PC_Write    = ~stall_cycle | Branch_Taken_MEM;
    assign Bubble_ID   = stall_cycle | ~Valid_ID;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state          <= RUN;
            stall_left     <= 3'd0;
            PC_Plus_4_ID   <= 32'd0;
            Instruction_ID <= 32'd0;
            Valid_ID       <= 1'b0;
            Stall_Count    <= '0;
        end else begin
            if (!PC_Write)
                Stall_Count <= sat_inc(Stall_Count);

            if (Branch_Taken_MEM) begin
                state          <= RUN;
                stall_left     <= 3'd0;
                PC_Plus_4_ID   <= 32'd0;
                Instruction_ID <= 32'd0;
                Valid_ID       <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (hazard) begin
                            // A single-cycle stall is fully covered by the detecting cycle.
                            if (LOAD_STALL_CYCLES > 1) begin
                                state      <= STALL;
                                stall_left <= STALL_INIT;
                            end
                        end else begin
                            PC_Plus_4_ID   <= PC_Plus_4_IF;
                            Instruction_ID <= Instruction_IF;
                            Valid_ID       <= 1'b1;
                        end
                    end
                    STALL: begin
                        if (stall_left <= 3'd1) begin
                            state      <= RUN;
                            stall_left <= 3'd0;
                        end else begin
                            stall_left <= stall_left - 3'd1;
                        end
                    end
                    default: begin
                        state      <= RUN;
                        stall_left <= 3'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Directed bench for if_id_hazard_stage: three instances cover N=1, N=3 and
// a 2-bit counter; all share the same input stimulus.
module tb_if_id_hazard_stage;

    logic        Clk;
    logic        Reset_n;
    logic [31:0] PC_Plus_4_IF;
    logic [31:0] Instruction_IF;
    logic        MemRead_EX;
    logic [31:0] Instruction_EX;
    logic        Branch_Taken_MEM;

    logic [31:0] pc_a, ins_a, pc_b, ins_b, pc_c, ins_c;
    logic        vld_a, pcw_a, bub_a, vld_b, pcw_b, bub_b, vld_c, pcw_c, bub_c;
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  cnt_c;

    int n_checks = 0;
    int n_fail   = 0;

    if_id_hazard_stage #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u_dut_n1 (
        .Clk(Clk), .Reset_n(Reset_n), .PC_Plus_4_IF(PC_Plus_4_IF),
        .Instruction_IF(Instruction_IF), .MemRead_EX(MemRead_EX),
        .Instruction_EX(Instruction_EX), .Branch_Taken_MEM(Branch_Taken_MEM),
        .PC_Plus_4_ID(pc_a), .Instruction_ID(ins_a), .Valid_ID(vld_a),
        .PC_Write(pcw_a), .Bubble_ID(bub_a), .Stall_Count(cnt_a));

    if_id_hazard_stage #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u_dut_n3 (
        .Clk(Clk), .Reset_n(Reset_n), .PC_Plus_4_IF(PC_Plus_4_IF),
        .Instruction_IF(Instruction_IF), .MemRead_EX(MemRead_EX),
        .Instruction_EX(Instruction_EX), .Branch_Taken_MEM(Branch_Taken_MEM),
        .PC_Plus_4_ID(pc_b), .Instruction_ID(ins_b), .Valid_ID(vld_b),
        .PC_Write(pcw_b), .Bubble_ID(bub_b), .Stall_Count(cnt_b));

    if_id_hazard_stage #(.LOAD_STALL_CYCLES(1), .CNT_W(2)) u_dut_sat (
        .Clk(Clk), .Reset_n(Reset_n), .PC_Plus_4_IF(PC_Plus_4_IF),
        .Instruction_IF(Instruction_IF), .MemRead_EX(MemRead_EX),
        .Instruction_EX(Instruction_EX), .Branch_Taken_MEM(Branch_Taken_MEM),
        .PC_Plus_4_ID(pc_c), .Instruction_ID(ins_c), .Valid_ID(vld_c),
        .PC_Write(pcw_c), .Bubble_ID(bub_c), .Stall_Count(cnt_c));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n          = 1'b0;
        PC_Plus_4_IF     = 32'd0;
        Instruction_IF   = 32'd0;
        MemRead_EX       = 1'b0;
        Instruction_EX   = 32'd0;
        Branch_Taken_MEM = 1'b0;
        tick();
        #1 Reset_n = 1'b1;
    endtask

    task automatic load(input logic [31:0] ins, input logic [31:0] pc);
        Instruction_IF = ins;
        PC_Plus_4_IF   = pc;
        tick();
    endtask

    initial begin
        // Reset values
        do_reset();
        Reset_n = 1'b0;
        #1;
        check("rst_pcw",   {31'd0, pcw_a}, 32'd1);
        check("rst_bub",   {31'd0, bub_a}, 32'd1);
        check("rst_vld",   {31'd0, vld_a}, 32'd0);
        check("rst_ins",   ins_a, 32'd0);
        check("rst_pc",    pc_a, 32'd0);
        check("rst_cnt",   {16'd0, cnt_a}, 32'd0);
        #1 Reset_n = 1'b1;

        // Pass-through
        load(32'h012A4020, 32'h4);
        check("pt_ins",  ins_a, 32'h012A4020);
        check("pt_pc",   pc_a, 32'h4);
        check("pt_vld",  {31'd0, vld_a}, 32'd1);
        check("pt_bub",  {31'd0, bub_a}, 32'd0);
        check("pt_pcw",  {31'd0, pcw_a}, 32'd1);

        // Load-use, N=1
        do_reset();
        load(32'h01095020, 32'h8);
        Instruction_IF = 32'h11111111;
        PC_Plus_4_IF   = 32'h0C;
        MemRead_EX     = 1'b1;
        Instruction_EX = 32'h8C080000;
        #1;
        check("n1_pcw_stall", {31'd0, pcw_a}, 32'd0);
        check("n1_bub_stall", {31'd0, bub_a}, 32'd1);
        tick();
        MemRead_EX = 1'b0;
        #1;
        check("n1_ins_held", ins_a, 32'h01095020);
        check("n1_cnt",      {16'd0, cnt_a}, 32'd1);
        check("n1_pcw_free", {31'd0, pcw_a}, 32'd1);
        check("n1_bub_free", {31'd0, bub_a}, 32'd0);
        tick();
        check("n1_ins_next", ins_a, 32'h11111111);
        check("n1_cnt_hold", {16'd0, cnt_a}, 32'd1);

        // No stall: rt=0, then non-matching rt, then matching rt field
        do_reset();
        load(32'h01095020, 32'h8);
        MemRead_EX     = 1'b1;
        Instruction_EX = 32'h8C000000;
        #1;
        check("rt0_pcw", {31'd0, pcw_a}, 32'd1);
        Instruction_EX = 32'h8C0B0000;
        #1;
        check("nomatch_pcw", {31'd0, pcw_a}, 32'd1);
        Instruction_EX = 32'h8C090000;
        #1;
        check("rtmatch_pcw", {31'd0, pcw_a}, 32'd0);
        MemRead_EX = 1'b0;
        #1;
        check("noload_pcw", {31'd0, pcw_a}, 32'd1);

        // Load-use, N=3
        do_reset();
        load(32'h01095020, 32'h8);
        Instruction_IF = 32'h22222222;
        PC_Plus_4_IF   = 32'h30;
        MemRead_EX     = 1'b1;
        Instruction_EX = 32'h8C080000;
        #1;
        check("n3_pcw_c0", {31'd0, pcw_b}, 32'd0);
        tick();
        MemRead_EX = 1'b0;
        #1;
        check("n3_pcw_c1", {31'd0, pcw_b}, 32'd0);
        tick();
        check("n3_pcw_c2", {31'd0, pcw_b}, 32'd0);
        check("n3_ins_c2", ins_b, 32'h01095020);
        tick();
        check("n3_pcw_c3", {31'd0, pcw_b}, 32'd1);
        check("n3_cnt",    {16'd0, cnt_b}, 32'd3);
        tick();
        check("n3_ins_next", ins_b, 32'h22222222);

        // Flush in second stall cycle, N=3
        do_reset();
        load(32'h01095020, 32'h8);
        MemRead_EX     = 1'b1;
        Instruction_EX = 32'h8C080000;
        tick();
        MemRead_EX       = 1'b0;
        Branch_Taken_MEM = 1'b1;
        #1;
        check("fl_pcw_same", {31'd0, pcw_b}, 32'd1);
        tick();
        Branch_Taken_MEM = 1'b0;
        Instruction_IF   = 32'h44444444;
        PC_Plus_4_IF     = 32'h50;
        #1;
        check("fl_ins", ins_b, 32'd0);
        check("fl_pc",  pc_b, 32'd0);
        check("fl_vld", {31'd0, vld_b}, 32'd0);
        check("fl_bub", {31'd0, bub_b}, 32'd1);
        check("fl_pcw", {31'd0, pcw_b}, 32'd1);
        check("fl_cnt", {16'd0, cnt_b}, 32'd1);
        tick();
        check("fl_reload", ins_b, 32'h44444444);

        // Reset mid-STALL, N=3
        do_reset();
        load(32'h01095020, 32'h8);
        MemRead_EX     = 1'b1;
        Instruction_EX = 32'h8C080000;
        tick();
        MemRead_EX = 1'b0;
        #1 Reset_n = 1'b0;
        #1 Reset_n = 1'b1;
        Instruction_IF = 32'h33333333;
        PC_Plus_4_IF   = 32'h40;
        #1;
        check("rs_pcw_after", {31'd0, pcw_b}, 32'd1);
        tick();
        check("rs_ins", ins_b, 32'h33333333);
        check("rs_vld", {31'd0, vld_b}, 32'd1);

        // Saturation with CNT_W=2, then asynchronous reset
        do_reset();
        load(32'h01095020, 32'h8);
        MemRead_EX     = 1'b1;
        Instruction_EX = 32'h8C080000;
        tick();
        tick();
        check("sat_cnt2", {30'd0, cnt_c}, 32'd2);
        tick();
        tick();
        tick();
        check("sat_cnt5", {30'd0, cnt_c}, 32'd3);
        check("sat_ins",  ins_c, 32'h01095020);
        #1 Reset_n = 1'b0;
        #1;
        check("ar_cnt", {30'd0, cnt_c}, 32'd0);
        check("ar_ins", ins_c, 32'd0);
        check("ar_pc",  pc_c, 32'd0);
        check("ar_vld", {31'd0, vld_c}, 32'd0);
        check("ar_pcw", {31'd0, pcw_c}, 32'd1);
        check("ar_bub", {31'd0, bub_c}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
